keypad_digit_capture: RTL and testbench
=======================================

Name: keypad_digit_capture

Overview:
- Scans a 4x4 matrix keypad, debounces one key press, and maintains the two most recently entered hex digits.
- Sits directly upstream of the dual seven-segment digit mux. Output s1 is the newest digit and s2 is the previous one. Both feed the mux's s1/s2 inputs.
- One key press shifts the digits exactly once, regardless of bounce or hold time.

Parameters:
- SCAN_DIV, default 20000: clock cycles each column is driven before advancing. Must be >= 4.
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a press or a release. Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. All state is cleared immediately when it is low.
- rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
- cols  output  4  keypad column drive, active-low, one-hot-low.
- s1  output  4  most recent accepted digit.
- s2  output  4  digit accepted before s1.
- key_valid  output  1  one-cycle pulse when a new digit is accepted.

Behaviour:
- Reset values: cols=4'b1110 (column 0), s1=4'h0, s2=4'h0, key_valid=0, state=SCAN, column index=0, counters=0. The rows synchronizer resets to 4'b1111.
- Synchronizer: rows passes through a 2-flop synchronizer giving rs. All decisions use rs only.
- Single press: exactly one bit of rs is low. Zero low bits or two or more low bits count as "no valid press".

State SCAN:
- Dwell counter counts 0..SCAN_DIV-1 on the current column.
- At count SCAN_DIV-1, if a single press is present: latch row index r and column index c, then go to DEBOUNCE with the column frozen.
- Otherwise, rotate cols to the next column (3 wraps to 0) and clear the dwell counter.

State DEBOUNCE:
- Counter increments each cycle while rs equals the latched pattern.
- Any mismatch returns to SCAN, advances to the next column, and clears the counter.
- At count DEBOUNCE_CYCLES-1 with a match, go to HELD. On that same edge: s2<=s1, s1<=decoded code, key_valid=1 for exactly one cycle.

State HELD:
- Column stays frozen.
- When rs==4'b1111, go to RELEASE with the counter cleared.
- Pressing extra keys is ignored; there is no second key_valid.

State RELEASE:
- Counter increments while rs==4'b1111.
- Any low bit returns to HELD.
- At count DEBOUNCE_CYCLES-1, go to SCAN at the next column with counters cleared.

Decode (row r, col c):
- r0: 1,2,3,A
- r1: 4,5,6,B
- r2: 7,8,9,C
- r3: E,0,F,D

Other rules:
- Latency from rows edge to key_valid, worst case: 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES cycles.
- s1/s2 change only on a key_valid cycle. They are registered outputs with no combinational path from rows.
- Reset asserted mid-operation (any state) clears everything immediately and restarts at column 0. A key still held at release of reset is accepted as a new press.
- Counters must be sized for the parameters ($clog2). No counter may overflow or wrap while holding.

Test Plan:
(All cases use SCAN_DIV=4, DEBOUNCE_CYCLES=8.)
- Reset: assert reset low mid-count -> cols=1110, s1=0, s2=0, key_valid=0 immediately, with no clock edge needed.
- Clean press: hold row1 low only while cols=1011 (col2) -> after debounce, s1=4'h6, s2=4'h0, key_valid high exactly 1 cycle.
- Two digits: press 5 (r1,c1), release, then press A (r0,c3) -> s1=A, s2=5. Exactly two key_valid pulses.
- Bounce: toggle row2 on col0 every 3 cycles for 30 cycles, then hold stable -> no key_valid during bounce; one pulse with s1=7 after 8 stable cycles.
- Long hold and release glitch: hold 0 (r3,c1) for 200 cycles, go high 3 cycles, low 2, then high 20 -> single key_valid, s1=0, FSM returns to SCAN only after 8 consecutive high cycles.
- Multi-key: two rows low on the same column -> no key_valid, scanning continues (cols keeps rotating).

Source files
------------

// File: rtl/keypad_digit_capture_if.sv
// Keypad and digit-output signal bundle for keypad_digit_capture.
// The master side is the capture block; the slave side is the keypad/display environment.
interface keypad_digit_capture_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       key_valid;

    modport master (
        input  rows,
        output cols,
        output s1,
        output s2,
        output key_valid
    );

    modport slave (
        output rows,
        input  cols,
        input  s1,
        input  s2,
        input  key_valid
    );
endinterface

// File: rtl/keypad_digit_capture.sv
// 4x4 keypad scanner with press/release debounce; keeps the two newest hex digits
// (s1 newest, s2 previous) and pulses key_valid once per accepted press.
module keypad_digit_capture #(
    parameter int SCAN_DIV        = 20000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    keypad_digit_capture_if.master        kp
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SCAN_LAST = cnt_t'(SCAN_DIV - 1);
    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    logic [3:0] rows_meta_q, rows_meta_d;
    logic [3:0] rs_q, rs_d;
    state_e     state_q, state_d;
    logic [1:0] col_q, col_d;
    cnt_t       cnt_q, cnt_d;
    logic [3:0] pat_q, pat_d;
    logic [1:0] row_q, row_d;
    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic       key_valid_q, key_valid_d;

    function automatic logic single_low(input logic [3:0] v);
        logic [3:0] a;
        a = ~v;
        return (a != 4'h0) && ((a & (a - 4'd1)) == 4'h0);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        rows_meta_d = kp.rows;
        rs_d        = rows_meta_q;
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        row_d       = row_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        key_valid_d = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (single_low(rs_q)) begin
                        pat_d   = rs_q;
                        row_d   = low_index(rs_q);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (rs_q != pat_q) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = ST_HELD;
                    cnt_d       = '0;
                    s2_d        = s1_q;
                    s1_d        = decode(row_q, col_q);
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_HELD: begin
                // Counter idles at zero here so an arbitrarily long hold cannot wrap it.
                cnt_d = '0;
                if (rs_q == 4'hF) state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (rs_q != 4'hF) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= 4'hF;
            rs_q        <= 4'hF;
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            cnt_q       <= '0;
            pat_q       <= 4'hF;
            row_q       <= 2'd0;
            s1_q        <= 4'h0;
            s2_q        <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            rows_meta_q <= rows_meta_d;
            rs_q        <= rs_d;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            row_q       <= row_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.cols      = ~(4'b0001 << col_q);
    assign kp.s1        = s1_q;
    assign kp.s2        = s2_q;
    assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Bench for keypad_digit_capture: a simulated key matrix drives rows from the scanned
// column, and a cycle-level reference model built from the keypad rules predicts outputs.
module tb_keypad_digit_capture;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    localparam int P_SCAN = 0;
    localparam int P_DEB  = 1;
    localparam int P_HELD = 2;
    localparam int P_REL  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    keypad_digit_capture_if io();

    keypad_digit_capture #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (io)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Key legend indexed by row*4 + col.
    logic [3:0] key_code [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    int         m_phase, m_cnt, m_col, m_row;
    logic [3:0] m_meta, m_rs, m_pat, m_s1, m_s2;
    logic       m_kv;
    logic [15:0] pressed;

    function automatic int key_idx(input int r, input int c);
        return r * 4 + c;
    endfunction

    function automatic int low_count(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_meta  = 4'hF;
        m_rs    = 4'hF;
        m_phase = P_SCAN;
        m_cnt   = 0;
        m_col   = 0;
        m_row   = 0;
        m_pat   = 4'hF;
        m_s1    = 4'h0;
        m_s2    = 4'h0;
        m_kv    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rows_now);
        m_kv = 1'b0;
        case (m_phase)
            P_SCAN: begin
                if (m_cnt == SCAN_DIV - 1) begin
                    m_cnt = 0;
                    if (low_count(m_rs) == 1) begin
                        m_pat = m_rs;
                        for (int i = 0; i < 4; i++) if (!m_rs[i]) m_row = i;
                        m_phase = P_DEB;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else m_cnt++;
            end
            P_DEB: begin
                if (m_rs != m_pat) begin
                    m_phase = P_SCAN;
                    m_col   = (m_col + 1) % 4;
                    m_cnt   = 0;
                end else if (m_cnt == DEB - 1) begin
                    m_phase = P_HELD;
                    m_cnt   = 0;
                    m_s2    = m_s1;
                    m_s1    = key_code[key_idx(m_row, m_col)];
                    m_kv    = 1'b1;
                end else m_cnt++;
            end
            P_HELD: begin
                if (m_rs == 4'hF) begin
                    m_phase = P_REL;
                    m_cnt   = 0;
                end
            end
            default: begin
                if (m_rs != 4'hF) begin
                    m_phase = P_HELD;
                    m_cnt   = 0;
                end else if (m_cnt == DEB - 1) begin
                    m_phase = P_SCAN;
                    m_col   = (m_col + 1) % 4;
                    m_cnt   = 0;
                end else m_cnt++;
            end
        endcase
        m_rs   = m_meta;
        m_meta = rows_now;
    endtask

    // Physical matrix: a row reads low when a pressed key sits on a driven (low) column.
    function automatic logic [3:0] matrix_rows();
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (pressed[key_idx(ri, ci)] && !io.cols[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        logic [3:0] exp_cols;
        io.rows = matrix_rows();
        @(posedge clk);
        model_step(io.rows);
        #1;
        exp_cols = ~(4'b0001 << m_col);
        check("cols", {28'd0, io.cols}, {28'd0, exp_cols});
        check("s1", {28'd0, io.s1}, {28'd0, m_s1});
        check("s2", {28'd0, io.s2}, {28'd0, m_s2});
        check("key_valid", {31'd0, io.key_valid}, {31'd0, m_kv});
        if (io.key_valid) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"}, {28'd0, io.cols}, 32'hE);
        check({tag, "_s1"}, {28'd0, io.s1}, 32'h0);
        check({tag, "_s2"}, {28'd0, io.s2}, 32'h0);
        check({tag, "_kv"}, {31'd0, io.key_valid}, 32'h0);
    endtask

    task automatic press_release(input int r, input int c);
        pressed = 16'h0;
        pressed[key_idx(r, c)] = 1'b1;
        ticks(40);
        pressed = 16'h0;
        ticks(30);
    endtask

    initial begin
        logic [3:0] seen_cols;
        int k, k2, nb;

        pressed = 16'h0;
        io.rows = 4'hF;
        reset   = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por_held");
        @(negedge clk);
        reset = 1'b1;

        ticks(12);

        // Clean press of 6 (row1, col2).
        pulses = 0;
        press_release(1, 2);
        check("clean_s1", {28'd0, io.s1}, 32'h6);
        check("clean_s2", {28'd0, io.s2}, 32'h0);
        check("clean_pulses", pulses, 1);

        // Two digits: 5 then A.
        pulses = 0;
        press_release(1, 1);
        press_release(0, 3);
        check("two_s1", {28'd0, io.s1}, 32'hA);
        check("two_s2", {28'd0, io.s2}, 32'h5);
        check("two_pulses", pulses, 2);

        // Asynchronous reset mid-operation with key 9 still held through release of reset.
        pressed = 16'h0;
        pressed[key_idx(2, 2)] = 1'b1;
        ticks(17);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        ticks(40);
        pressed = 16'h0;
        ticks(30);
        check("held_thru_rst_s1", {28'd0, io.s1}, 32'h9);
        check("held_thru_rst_s2", {28'd0, io.s2}, 32'h0);
        check("held_thru_rst_pulses", pulses, 1);

        // Bounce on 7 (row2, col0): toggles every 3 cycles, then settles.
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            pressed = ((i / 3) % 2 == 0) ? 16'h0100 : 16'h0;
            tick();
        end
        check("bounce_quiet", pulses, 0);
        pressed = 16'h0100;
        ticks(40);
        pressed = 16'h0;
        ticks(30);
        check("bounce_s1", {28'd0, io.s1}, 32'h7);
        check("bounce_s2", {28'd0, io.s2}, 32'h9);
        check("bounce_pulses", pulses, 1);

        // Long hold of 0 (row3, col1) with a short release glitch.
        pulses = 0;
        pressed = 16'h0;
        pressed[key_idx(3, 1)] = 1'b1;
        ticks(200);
        pressed = 16'h0;
        ticks(3);
        pressed[key_idx(3, 1)] = 1'b1;
        ticks(2);
        check("glitch_frozen", {28'd0, io.cols}, 32'hD);
        pressed = 16'h0;
        ticks(10);
        check("release_wait", {28'd0, io.cols}, 32'hD);
        ticks(1);
        check("release_done", {28'd0, io.cols}, 32'hB);
        ticks(9);
        check("hold_s1", {28'd0, io.s1}, 32'h0);
        check("hold_s2", {28'd0, io.s2}, 32'h7);
        check("hold_pulses", pulses, 1);

        // Two rows low on column 0: never a single press, scanning keeps rotating.
        pulses    = 0;
        seen_cols = 4'h0;
        pressed   = 16'h0;
        pressed[key_idx(0, 0)] = 1'b1;
        pressed[key_idx(1, 0)] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            seen_cols = seen_cols | ~io.cols;
        end
        check("multi_pulses", pulses, 0);
        check("multi_rotates", {28'd0, seen_cols}, 32'hF);
        pressed = 16'h0;
        ticks(20);

        // Randomized presses, bounces and chords against the reference model.
        for (int it = 0; it < 24; it++) begin
            k  = $urandom_range(0, 15);
            nb = $urandom_range(0, 20);
            for (int i = 0; i < nb; i++) begin
                pressed = 16'h0;
                if ($urandom_range(0, 1) == 1) pressed[k] = 1'b1;
                tick();
            end
            pressed = 16'h0;
            pressed[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k2 = $urandom_range(0, 15);
                pressed[k2] = 1'b1;
            end
            ticks($urandom_range(30, 90));
            pressed = 16'h0;
            ticks($urandom_range(15, 40));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
